seg7_capture: RTL and testbench

SEG7_CAPTURE -- requirements
Module: seg7_capture

---
 rtl/seg7_capture.sv | 149 ++++++++++++++
 tb/tb_seg7_capture.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// Seven-segment display scanner: debounces multiplexed digit samples, assembles a
// frame of DIGITS decoded nibbles and hands it off with valid/ready. Option macro: SEG7_CAPTURE_ERR_EN.
module seg7_capture #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_err,
  output logic                  out_ovf,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic {COLLECT, FULL} state_e;

  state_e              state_q, state_d;
  logic [6:0]          seg_q;
  logic [DIGITS-1:0]   sel_q;
  logic [7:0]          cnt_q, cnt_d;
  logic [4*DIGITS-1:0] slot_q, slot_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                err_q, err_d;
  logic                ovf_q, ovf_d;
  logic                valid_q, valid_d;

  logic [3:0]          dec_nib;
  logic                one_hot, match, write_en, frame_err;

  // Invalid patterns decode to F, which no legal digit produces, so F doubles as the invalid flag.
  always_comb begin
    dec_nib = 4'hF;
    case (seg)
      7'h7E: dec_nib = 4'd0;
      7'h30: dec_nib = 4'd1;
      7'h6D: dec_nib = 4'd2;
      7'h79: dec_nib = 4'd3;
      7'h33: dec_nib = 4'd4;
      7'h5B: dec_nib = 4'd5;
      7'h5F: dec_nib = 4'd6;
      7'h70: dec_nib = 4'd7;
      7'h7F: dec_nib = 4'd8;
      7'h7B: dec_nib = 4'd9;
      default: dec_nib = 4'hF;
    endcase
  end

`ifdef SEG7_CAPTURE_ERR_EN
  always_comb begin
    frame_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (slot_q[4*i +: 4] == 4'hF) frame_err = 1'b1;
    end
  end
`else
  assign frame_err = 1'b0;
`endif

  assign one_hot  = (dig_sel != '0) && ((dig_sel & (dig_sel - DIGITS'(1))) == '0);
  assign match    = (seg == seg_q) && (dig_sel == sel_q);
  // Fires only on the transition into saturation, giving one write per stable period.
  assign write_en = match && (cnt_q == 8'(STABLE_CYC - 1)) && one_hot;

  always_comb begin
    if (!match) begin
      cnt_d = 8'd1;
    end else if (cnt_q == 8'(STABLE_CYC)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    slot_d  = slot_q;
    bcd_d   = bcd_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;

    if (valid_q && out_ready) valid_d = 1'b0;

    case (state_q)
      COLLECT: begin
        if (&seen_q) state_d = FULL;
      end
      FULL: begin
        state_d = COLLECT;
        seen_d  = '0;
        if (!valid_q || out_ready) begin
          bcd_d   = slot_q;
          err_d   = frame_err;
          valid_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase

    // A write in the FULL cycle lands after the clear and so starts the next frame.
    if (write_en) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (dig_sel[i]) begin
          slot_d[4*i +: 4] = dec_nib;
          seen_d[i]        = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      seg_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      slot_q  <= '0;
      seen_q  <= '0;
      bcd_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg;
      sel_q   <= dig_sel;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      seen_q  <= seen_d;
      bcd_q   <= bcd_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign out_bcd   = bcd_q;
  assign out_err   = err_q;
  assign out_ovf   = ovf_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture (DIGITS=4, STABLE_CYC=4): inputs change on the falling
// edge, outputs are sampled on the falling edge. Honors SEG7_CAPTURE_ERR_EN for out_err expectations.
module tb_seg7_capture;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  digSel;
  logic [15:0] outBcd;
  logic        outErr;
  logic        outOvf;
  logic        outValid;
  logic        outReady;

  int checks;
  int errors;

`ifdef SEG7_CAPTURE_ERR_EN
  localparam logic ExpErr = 1'b1;
`else
  localparam logic ExpErr = 1'b0;
`endif

  seg7_capture #(.DIGITS(4), .STABLE_CYC(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .dig_sel   (digSel),
    .out_bcd   (outBcd),
    .out_err   (outErr),
    .out_ovf   (outOvf),
    .out_valid (outValid),
    .out_ready (outReady)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Called on a falling edge; holds the pattern across n rising edges and returns on a falling edge.
  task automatic applyStimulus(input logic [6:0] s, input logic [3:0] sel, input int n);
    seg    = s;
    digSel = sel;
    repeat (n) @(negedge clk);
  endtask

  // Final slot write has just happened; with outReady=1 expect valid two edges later for one cycle.
  task automatic expectFrame(input string tag, input logic [15:0] bcd, input logic err);
    seg    = 7'h00;
    digSel = 4'b0000;
    checkOutput({tag, "_valid_e0"}, 32'(outValid), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_valid_e1"}, 32'(outValid), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_valid_e2"}, 32'(outValid), 32'd1);
    checkOutput({tag, "_bcd"}, 32'(outBcd), 32'(bcd));
    checkOutput({tag, "_err"}, 32'(outErr), 32'(err));
    @(negedge clk);
    checkOutput({tag, "_valid_e3"}, 32'(outValid), 32'd0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    clk      = 1'b0;
    rst_n    = 1'b0;
    seg      = 7'h00;
    digSel   = 4'b0000;
    outReady = 1'b1;

    #12;
    checkOutput("reset_bcd",   32'(outBcd),   32'd0);
    checkOutput("reset_valid", 32'(outValid), 32'd0);
    checkOutput("reset_err",   32'(outErr),   32'd0);
    checkOutput("reset_ovf",   32'(outOvf),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic frame 1,2,3,4");
    applyStimulus(7'h30, 4'b0001, 4);
    applyStimulus(7'h6D, 4'b0010, 4);
    applyStimulus(7'h79, 4'b0100, 4);
    applyStimulus(7'h33, 4'b1000, 4);
    expectFrame("basic", 16'h4321, 1'b0);

    $display("[TB] short hold is not written");
    applyStimulus(7'h5F, 4'b0001, 3);
    applyStimulus(7'h7E, 4'b0001, 4);
    applyStimulus(7'h6D, 4'b0010, 4);
    applyStimulus(7'h79, 4'b0100, 4);
    applyStimulus(7'h33, 4'b1000, 4);
    expectFrame("short", 16'h4320, 1'b0);

    $display("[TB] short hold after a write leaves slot intact");
    applyStimulus(7'h7E, 4'b0001, 4);
    applyStimulus(7'h5F, 4'b0001, 3);
    applyStimulus(7'h6D, 4'b0010, 4);
    applyStimulus(7'h79, 4'b0100, 4);
    applyStimulus(7'h33, 4'b1000, 4);
    expectFrame("keep", 16'h4320, 1'b0);

    $display("[TB] overwrite, latest value wins");
    applyStimulus(7'h5F, 4'b0001, 4);
    applyStimulus(7'h70, 4'b0001, 4);
    applyStimulus(7'h6D, 4'b0010, 4);
    applyStimulus(7'h79, 4'b0100, 4);
    applyStimulus(7'h33, 4'b1000, 4);
    expectFrame("overwrite", 16'h4327, 1'b0);

    $display("[TB] invalid pattern");
    applyStimulus(7'h30, 4'b0001, 4);
    applyStimulus(7'h6D, 4'b0010, 4);
    applyStimulus(7'h01, 4'b0100, 4);
    applyStimulus(7'h33, 4'b1000, 4);
    expectFrame("invalid", 16'h4F21, ExpErr);

    $display("[TB] overflow with consumer stalled");
    outReady = 1'b0;
    applyStimulus(7'h30, 4'b0001, 4);
    applyStimulus(7'h6D, 4'b0010, 4);
    applyStimulus(7'h79, 4'b0100, 4);
    applyStimulus(7'h33, 4'b1000, 4);
    seg    = 7'h00;
    digSel = 4'b0000;
    repeat (2) @(negedge clk);
    checkOutput("ovf_first_valid", 32'(outValid), 32'd1);
    checkOutput("ovf_first_bcd",   32'(outBcd),   32'h4321);
    checkOutput("ovf_first_err",   32'(outErr),   32'd0);
    applyStimulus(7'h5B, 4'b0001, 4);
    applyStimulus(7'h5F, 4'b0010, 4);
    applyStimulus(7'h70, 4'b0100, 4);
    applyStimulus(7'h7F, 4'b1000, 4);
    seg    = 7'h00;
    digSel = 4'b0000;
    checkOutput("ovf_before", 32'(outOvf), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("ovf_set",        32'(outOvf),   32'd1);
    checkOutput("ovf_hold_valid", 32'(outValid), 32'd1);
    checkOutput("ovf_hold_bcd",   32'(outBcd),   32'h4321);
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("ovf_drain_valid", 32'(outValid), 32'd0);
    checkOutput("ovf_sticky",      32'(outOvf),   32'd1);

    $display("[TB] reset mid-frame");
    applyStimulus(7'h30, 4'b0001, 4);
    applyStimulus(7'h6D, 4'b0010, 4);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ovf",   32'(outOvf),   32'd0);
    checkOutput("midrst_bcd",   32'(outBcd),   32'd0);
    checkOutput("midrst_valid", 32'(outValid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(7'h7B, 4'b0100, 4);
    applyStimulus(7'h7B, 4'b1000, 4);
    applyStimulus(7'h7B, 4'b0001, 4);
    applyStimulus(7'h7B, 4'b0010, 4);
    expectFrame("rst9999", 16'h9999, 1'b0);

    $display("[TB] two-hot select ignored");
    applyStimulus(7'h7B, 4'b0100, 4);
    applyStimulus(7'h7B, 4'b1000, 4);
    applyStimulus(7'h7E, 4'b0011, 10);
    seg    = 7'h00;
    digSel = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("twohot_idle%0d", i), 32'(outValid), 32'd0);
    end
    applyStimulus(7'h30, 4'b0001, 4);
    applyStimulus(7'h6D, 4'b0010, 4);
    expectFrame("twohot", 16'h9921, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
